// File: rtl/matrix_dpram_if.sv
// Write/read/clear bundle for matrix_dpram; master drives requests, slave is the RAM.
interface matrix_dpram_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANE_WIDTH = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8
);
    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;

    logic                  clr_req;
    logic                  clr_busy;
    logic                  we;
    logic [LANES-1:0]      wbe;
    logic [RW-1:0]         w_row;
    logic [CW-1:0]         w_col;
    logic [DATA_WIDTH-1:0] din;
    logic                  re;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  addr_err;

    modport master (
        output clr_req, we, wbe, w_row, w_col, din, re, r_row, r_col,
        input  clr_busy, dout, dout_valid, addr_err
    );

    modport slave (
        input  clr_req, we, wbe, w_row, w_col, din, re, r_row, r_col,
        output clr_busy, dout, dout_valid, addr_err
    );
endinterface

// File: rtl/matrix_dpram.sv
// Row/column addressed simple-dual-port RAM with lane write enables, 1/2-cycle read
// latency and a sequential clear engine instead of an array reset.
module matrix_dpram #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned LANE_WIDTH     = 8,
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    matrix_dpram_if.slave  bus
);
    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned DEPTH = ROWS * COLS;
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state;
    logic [IW-1:0]         clr_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clearing_c;
    logic                  w_in_c;
    logic                  r_in_c;
    logic                  wr_ok_c;
    logic [IW-1:0]         w_idx_c;
    logic [IW-1:0]         r_idx_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    logic                  v1, v2;
    logic [DATA_WIDTH-1:0] d1, d2;
    logic                  err_q;

    assign clearing_c = (state == CLEAR);
    assign w_in_c     = (32'(bus.w_row) < ROWS) && (32'(bus.w_col) < COLS);
    assign r_in_c     = (32'(bus.r_row) < ROWS) && (32'(bus.r_col) < COLS);
    // A clr_req accepted this cycle starts the sweep, so the coincident write loses.
    assign wr_ok_c    = bus.we && !clearing_c && !bus.clr_req && w_in_c;
    assign w_idx_c    = IW'(32'(bus.w_row) * COLS + 32'(bus.w_col));
    assign r_idx_c    = IW'(32'(bus.r_row) * COLS + 32'(bus.r_col));

    // Clear engine: one word per cycle, row-major, then back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_idx == IW'(DEPTH - 1)) begin
                        state   <= IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + IW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    clr_idx <= '0;
                end
            endcase
        end
    end

    // Array has no reset term so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (clearing_c) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok_c) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.wbe[k]) begin
                    mem[w_idx_c][k*LANE_WIDTH +: LANE_WIDTH] <= bus.din[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_word_c = mem[r_idx_c];
        if ((RDW_MODE != 0) && wr_ok_c && (w_idx_c == r_idx_c)) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.wbe[k]) begin
                    rd_word_c[k*LANE_WIDTH +: LANE_WIDTH] = bus.din[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        if (clearing_c || !r_in_c) begin
            rd_word_c = '0;
        end
    end

    // Read pipeline; data stages only load on a valid so dout holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            d1    <= '0;
            d2    <= '0;
            err_q <= 1'b0;
        end else begin
            v1 <= bus.re;
            v2 <= v1;
            if (bus.re) d1 <= rd_word_c;
            if (v1)     d2 <= d1;
            err_q <= err_q | (bus.we && !w_in_c) | (bus.re && !r_in_c);
        end
    end

    assign bus.dout       = (RD_LATENCY == 2) ? d2 : d1;
    assign bus.dout_valid = (RD_LATENCY == 2) ? v2 : v1;
    assign bus.addr_err   = err_q;
    assign bus.clr_busy   = clearing_c;
endmodule

// File: tb/tb_matrix_dpram.sv
// Drives two matrix_dpram variants with shared stimulus; a word-level model predicts
// every read, and per-DUT monitors check returned data, latency, hold, busy and error.
module tb_matrix_dpram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        clr_req, we, re;
    logic [1:0]  wbe;
    logic [2:0]  w_row, w_col, r_row, r_col;
    logic [15:0] din;

    matrix_dpram_if #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ROWS(8), .COLS(8)) if0 ();
    matrix_dpram_if #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ROWS(6), .COLS(8)) if1 ();

    assign if0.clr_req = clr_req; assign if1.clr_req = clr_req;
    assign if0.we = we;           assign if1.we = we;
    assign if0.wbe = wbe;         assign if1.wbe = wbe;
    assign if0.w_row = w_row;     assign if1.w_row = w_row;
    assign if0.w_col = w_col;     assign if1.w_col = w_col;
    assign if0.din = din;         assign if1.din = din;
    assign if0.re = re;           assign if1.re = re;
    assign if0.r_row = r_row;     assign if1.r_row = r_row;
    assign if0.r_col = r_col;     assign if1.r_col = r_col;

    matrix_dpram #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ROWS(8), .COLS(8),
                   .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    matrix_dpram #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ROWS(6), .COLS(8),
                   .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q0[$], q1[$];
    logic [15:0] mem_m [2][64];
    int          clr_left [2];
    bit          err_m [2];
    logic [15:0] last_m [2];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rows_of(int d); return (d == 0) ? 8 : 6; endfunction
    function automatic int lat_of(int d);  return (d == 0) ? 1 : 2; endfunction
    function automatic bit rdw_of(int d);  return d != 0;           endfunction

    function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] nw, logic [1:0] be);
        logic [15:0] r = old;
        if (be[0]) r[7:0]  = nw[7:0];
        if (be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        else passes++;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            clr_left[d] = rows_of(d) * 8;
            err_m[d] = 1'b0;
            last_m[d] = '0;
            for (int i = 0; i < 64; i++) mem_m[d][i] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One cycle of the spec's word-level behaviour for DUT d, given the current inputs.
    task automatic model_step(int d);
        bit clearing = clr_left[d] > 0;
        bit w_in = (int'(w_row) < rows_of(d)) && (int'(w_col) < 8);
        bit r_in = (int'(r_row) < rows_of(d)) && (int'(r_col) < 8);
        bit wr_ok = we && !clearing && !clr_req && w_in;
        int wi = int'(w_row) * 8 + int'(w_col);
        int ri = int'(r_row) * 8 + int'(r_col);
        exp_t e;
        if (re) begin
            e.data = (clearing || !r_in) ? 16'h0 : mem_m[d][ri];
            if (rdw_of(d) && wr_ok && wi == ri) e.data = merge(e.data, din, wbe);
            e.due = cyc + lat_of(d);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (wr_ok) mem_m[d][wi] = merge(mem_m[d][wi], din, wbe);
        if ((we && !w_in) || (re && !r_in)) err_m[d] = 1'b1;
        if (clearing) clr_left[d]--;
        else if (clr_req) begin
            clr_left[d] = rows_of(d) * 8;
            for (int i = 0; i < 64; i++) mem_m[d][i] = '0;
        end
    endtask

    task automatic idle();
        clr_req = 0; we = 0; re = 0; wbe = 0;
        w_row = 0; w_col = 0; r_row = 0; r_col = 0; din = 0;
    endtask

    task automatic go();
        model_step(0);
        model_step(1);
        @(negedge clk); #1;
        idle();
    endtask

    task automatic wr(int r, int c, logic [15:0] d, logic [1:0] be);
        we = 1; w_row = 3'(r); w_col = 3'(c); din = d; wbe = be;
        go();
    endtask

    task automatic rd(int r, int c);
        re = 1; r_row = 3'(r); r_col = 3'(c);
        go();
    endtask

    task automatic do_reset(int hold);
        rst_n = 0;
        model_reset();
        repeat (hold) begin @(negedge clk); #1; end
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if0.dout_valid) begin
            if (q0.size() == 0) chk("u0_unexpected_valid", 1, 0);
            else begin
                e = q0.pop_front();
                chk("u0_rd_data", 32'(if0.dout), 32'(e.data));
                chk("u0_rd_latency", cyc, e.due);
                last_m[0] = e.data;
            end
        end else begin
            if (q0.size() > 0 && q0[0].due <= cyc) begin
                chk("u0_missing_valid", 0, 1);
                void'(q0.pop_front());
            end
            chk("u0_dout_hold", 32'(if0.dout), 32'(last_m[0]));
        end
        chk("u0_clr_busy", 32'(if0.clr_busy), 32'(clr_left[0] > 0));
        chk("u0_addr_err", 32'(if0.addr_err), 32'(err_m[0]));
    end

    always @(negedge clk) begin
        exp_t e;
        if (if1.dout_valid) begin
            if (q1.size() == 0) chk("u1_unexpected_valid", 1, 0);
            else begin
                e = q1.pop_front();
                chk("u1_rd_data", 32'(if1.dout), 32'(e.data));
                chk("u1_rd_latency", cyc, e.due);
                last_m[1] = e.data;
            end
        end else begin
            if (q1.size() > 0 && q1[0].due <= cyc) begin
                chk("u1_missing_valid", 0, 1);
                void'(q1.pop_front());
            end
            chk("u1_dout_hold", 32'(if1.dout), 32'(last_m[1]));
        end
        chk("u1_clr_busy", 32'(if1.clr_busy), 32'(clr_left[1] > 0));
        chk("u1_addr_err", 32'(if1.addr_err), 32'(err_m[1]));
    end

    initial begin
        idle();
        model_reset();
        repeat (2) begin @(negedge clk); #1; end
        rst_n = 1;
        repeat (70) go();

        rd(7, 7);
        go();

        wr(2, 3, 16'hABCD, 2'b11);
        wr(2, 3, 16'h0012, 2'b01);
        rd(2, 3);
        go();

        wr(1, 1, 16'h1111, 2'b11);
        we = 1; w_row = 1; w_col = 1; din = 16'h5555; wbe = 2'b11;
        re = 1; r_row = 1; r_col = 1;
        go();
        rd(1, 1);
        go(); go();

        wr(0, 0, 16'h0001, 2'b11);
        wr(0, 1, 16'h0002, 2'b11);
        wr(0, 2, 16'h0003, 2'b11);
        rd(0, 0); rd(0, 1); rd(0, 2);
        go(); go(); go();

        wr(6, 0, 16'hFFFF, 2'b11);
        rd(6, 0);
        rd(0, 0);
        go(); go();

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                wr(r, c, 16'(r * 8 + c + 1) | 16'h0100, 2'b11);
        clr_req = 1;
        go();
        repeat (10) go();
        do_reset(2);
        repeat (70) go();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                rd(r, c);
        repeat (4) go();

        repeat (3000) begin
            clr_req = ($urandom_range(0, 199) == 0);
            we      = $urandom_range(0, 1) == 1;
            re      = $urandom_range(0, 1) == 1;
            wbe     = 2'($urandom_range(0, 3));
            w_row   = 3'($urandom_range(0, 7));
            w_col   = 3'($urandom_range(0, 7));
            r_row   = ($urandom_range(0, 3) == 0) ? w_row : 3'($urandom_range(0, 7));
            r_col   = ($urandom_range(0, 3) == 0) ? w_col : 3'($urandom_range(0, 7));
            din     = 16'($urandom);
            go();
        end
        repeat (5) go();

        chk("u0_queue_drained", q0.size(), 0);
        chk("u1_queue_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/matrix_dpram.md
Name: matrix_dpram

Overview:
Parametrised 2D (row/column addressed) simple-dual-port RAM: one write port, one read port, single clock.
Adds per-lane write enables, a selectable read latency with a valid strobe, and a defined read-during-write mode.
Replaces bulk asynchronous memory reset with a sequential clear engine, so the array can map onto block RAM.
Used as the matrix/tile buffer between producer and consumer datapaths.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH.
LANE_WIDTH, 8, write-enable granularity in bits; LANES = DATA_WIDTH/LANE_WIDTH.
ROWS, 8, number of rows; need not be a power of two.
COLS, 8, number of columns; need not be a power of two.
RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2.
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (merged) data.
CLEAR_ON_RESET, 1, 1 = run a clear sweep automatically after reset deasserts.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
clr_req  in  1  one-cycle pulse that starts a clear sweep.
clr_busy  out  1  high while a clear sweep is running.
we  in  1  write enable.
wbe  in  LANES  per-lane write enable; lane k is din[k*LANE_WIDTH +: LANE_WIDTH].
w_row  in  clog2(ROWS)  write row address.
w_col  in  clog2(COLS)  write column address.
din  in  DATA_WIDTH  write data.
re  in  1  read request.
r_row  in  clog2(ROWS)  read row address.
r_col  in  clog2(COLS)  read column address.
dout  out  DATA_WIDTH  read data.
dout_valid  out  1  one-cycle strobe, aligned with dout.
addr_err  out  1  sticky flag: an out-of-range access occurred.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: dout=0, dout_valid=0, addr_err=0, read pipeline cleared. clr_busy=1 if CLEAR_ON_RESET else 0.
- The memory array has no reset term; its contents are zeroed only by the clear engine.
- Clear FSM has two states, IDLE and CLEAR.
  - Reset enters CLEAR if CLEAR_ON_RESET, otherwise IDLE.
  - IDLE -> CLEAR on clr_req.
  - In CLEAR, an index advances 0..ROWS*COLS-1, writing 0 to one word per cycle (row-major).
  - After the last word the FSM returns to IDLE: clr_busy falls exactly ROWS*COLS cycles after entering CLEAR.
  - clr_req while in CLEAR is ignored; the sweep does not restart.
  - rst_n asserted mid-sweep aborts the sweep; behaviour then follows the reset rules above.
- Write: when we=1, not clearing and the address is in range, lanes with wbe[k]=1 update at the clock edge. Lanes with wbe[k]=0 keep their value. wbe=0 is a no-op.
- Read: re sampled in cycle N. dout and dout_valid=1 appear after edge N+RD_LATENCY.
  - dout_valid is high for exactly one cycle per accepted read.
  - Reads are fully pipelined: one read per cycle.
  - dout holds its last value when no read completes.
- Read during clear: the read is accepted and returns 0 with dout_valid=1.
- Read-during-write on the same address in the same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the old word with the enabled lanes replaced by din.
- Out of range (w_row>=ROWS, w_col>=COLS, r_row>=ROWS or r_col>=COLS):
  - An out-of-range write is dropped.
  - An out-of-range read returns 0 with dout_valid=1.
  - Either case sets addr_err, which clears only on reset.
- Writes are dropped while clr_busy=1, and addr_err is not set for them unless the address is also out of range.
- Simultaneous clr_req and we in IDLE: the write is dropped, because the sweep starts that cycle.

Test Plan:
1. Release reset (defaults) -> clr_busy=1 for 64 cycles then 0. A read of (7,7) returns 0x0000 with dout_valid=1 one cycle after re.
2. Write (2,3)=0xABCD with wbe=2'b11, then wbe=2'b01 with din=0x0012 -> a read of (2,3) returns 0xAB12.
3. Same cycle: write (1,1)=0x5555 and read (1,1) over old 0x1111 -> RDW_MODE=0 returns 0x1111, RDW_MODE=1 returns 0x5555. A following read returns 0x5555 in both modes.
4. RD_LATENCY=2: back-to-back reads of (0,0)=0x0001, (0,1)=0x0002, (0,2)=0x0003 -> dout shows 1, 2, 3 on consecutive cycles, starting 2 cycles after the first re, with dout_valid high for 3 cycles.
5. ROWS=6: write (6,0)=0xFFFF -> addr_err=1. A read of (6,0) returns 0, and a read of (0,0) is unchanged.
6. Fill the array with nonzero data and pulse clr_req. At sweep cycle 10, assert rst_n=0 -> clr_busy is set per CLEAR_ON_RESET, dout=0, dout_valid=0. After the sweep completes, all words read 0.
